// File: rtl/basys_mem_pkg.sv
// basys_mem_pkg: shared button indices, FSM states and LED layout helper for basys_mem_bank.
package basys_mem_pkg;
    localparam int BTN_WRITE     = 0;
    localparam int BTN_READ      = 1;
    localparam int BTN_ADDR_LOAD = 2;
    localparam int BTN_INC       = 3;
    localparam int BTN_CLEAR     = 4;
    localparam int NUM_BTN       = 5;

    typedef enum logic [1:0] {IDLE, READ_WAIT, CLEAR} state_t;

    // The busy flag sits directly above the data field on the LEDs.
    function automatic int busy_bit(input int data_w);
        return data_w;
    endfunction
endpackage

// File: rtl/basys_mem_bank_if.sv
// basys_mem_bank_if: board-side switch/button/LED bundle for basys_mem_bank.
interface basys_mem_bank_if;
    logic [15:0] SW;
    logic [4:0]  BTN;
    logic [15:0] LED;

    modport master (output SW, output BTN, input LED);
    modport slave (input SW, input BTN, output LED);
endinterface

// File: rtl/basys_mem_bank_btn_conditioner.sv
// btn_conditioner: 2-flop synchroniser, optional debounce and rising-edge pulse for one button.
// Debounce is built only when BASYS_MEM_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_in,
    output logic pulse_out
);
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end

    logic s1, s2, lvl, prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            prev      <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            s1        <= btn_in;
            s2        <= s1;
            prev      <= lvl;
            pulse_out <= lvl && !prev;
        end
    end

`ifdef BASYS_MEM_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;

    // The level only follows s2 once it has disagreed for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (s2 == lvl) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            lvl <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign lvl = s2;
`endif
endmodule

// File: rtl/basys_mem_bank.sv
// basys_mem_bank: switch/button driven memory bank with auto-increment, clear sweep and busy lockout.
// Define BASYS_MEM_DEBOUNCE_EN to debounce the buttons.
module basys_mem_bank
    import basys_mem_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic CLK,
    input logic RST,
    basys_mem_bank_if.slave bus
);
    if (DATA_W < 1 || DATA_W > 12 || ADDR_W < 1 || DATA_W + ADDR_W > 16) begin : g_bad_params
        $error("basys_mem_bank: illegal DATA_W/ADDR_W combination");
    end

    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [NUM_BTN-1:0] pulse;
    state_t             state, state_next;
    logic [ADDR_W-1:0]  ptr, ptr_next, sweep, sweep_next, mem_addr, sw_addr;
    logic [DATA_W-1:0]  data, data_next, rdata, mem_wdata, sw_data;
    logic               busy, busy_next, mem_we, idle, done;
    logic               do_clr, do_ld, do_wr, do_rd, do_inc;
    logic [DATA_W-1:0]  mem [2**ADDR_W];
    logic               unused_sw;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
            .CLK      (CLK),
            .RST      (RST),
            .btn_in   (bus.BTN[b]),
            .pulse_out(pulse[b])
        );
    end

    assign sw_data   = bus.SW[DATA_W-1:0];
    assign sw_addr   = bus.SW[15 -: ADDR_W];
    assign unused_sw = ^bus.SW;

    // Commands are only accepted in IDLE; each one masks everything of lower priority.
    always_comb begin
        idle   = state == IDLE;
        do_clr = idle && pulse[BTN_CLEAR];
        do_ld  = idle && pulse[BTN_ADDR_LOAD] && !pulse[BTN_CLEAR];
        do_wr  = idle && pulse[BTN_WRITE] && !pulse[BTN_ADDR_LOAD] && !pulse[BTN_CLEAR];
        do_rd  = idle && pulse[BTN_READ] && !pulse[BTN_WRITE] && !pulse[BTN_ADDR_LOAD] && !pulse[BTN_CLEAR];
        do_inc = idle && pulse[BTN_INC] && !pulse[BTN_READ] && !pulse[BTN_WRITE] &&
                 !pulse[BTN_ADDR_LOAD] && !pulse[BTN_CLEAR];
        done   = state == CLEAR && sweep == LAST;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = do_clr ? CLEAR :
                     do_rd  ? READ_WAIT :
                     (state == READ_WAIT || done) ? IDLE : state;
    end

    always_comb begin
        mem_we     = do_wr || state == CLEAR;
        mem_addr   = state == CLEAR ? sweep : ptr;
        mem_wdata  = state == CLEAR ? '0 : sw_data;
        ptr_next   = do_ld ? sw_addr : (do_wr || do_inc) ? ptr + 1'b1 : done ? '0 : ptr;
        data_next  = do_wr ? sw_data : state == READ_WAIT ? rdata : done ? '0 : data;
        sweep_next = state == CLEAR ? sweep + 1'b1 : '0;
        busy_next  = do_clr || (state == CLEAR && !done);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr   <= '0;
            data  <= '0;
            sweep <= '0;
            busy  <= 1'b0;
        end else begin
            ptr   <= ptr_next;
            data  <= data_next;
            sweep <= sweep_next;
            busy  <= busy_next;
        end
    end

    // The array is deliberately left out of reset so an aborted sweep keeps untouched entries.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rdata <= mem[ptr];
    end

    always_comb begin
        bus.LED                   = '0;
        bus.LED[DATA_W-1:0]       = data;
        bus.LED[busy_bit(DATA_W)] = busy;
        bus.LED[15 -: ADDR_W]     = ptr;
    end
endmodule

// File: tb/tb_basys_mem_bank.sv
// tb_basys_mem_bank: randomized self-checking bench for basys_mem_bank against a command-level model.
module tb_basys_mem_bank;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m_ptr, m_data;
    int   m_mem[16];

    basys_mem_bank_if bus();

    basys_mem_bank dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] exp_led();
        return 16'((m_ptr << 12) | m_data);
    endfunction

    // Effect of one accepted command, highest priority first.
    function automatic void model(input logic [4:0] m, input logic [15:0] sw);
        if (m[4]) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_ptr  = 0;
            m_data = 0;
        end else if (m[2]) begin
            m_ptr = int'(sw[15:12]);
        end else if (m[0]) begin
            m_mem[m_ptr] = int'(sw[7:0]);
            m_data       = int'(sw[7:0]);
            m_ptr        = (m_ptr + 1) % 16;
        end else if (m[1]) begin
            m_data = m_mem[m_ptr];
        end else if (m[3]) begin
            m_ptr = (m_ptr + 1) % 16;
        end
    endfunction

    task automatic press(input logic [4:0] m, input logic [15:0] sw, input int hold);
        @(negedge CLK);
        bus.SW  = sw;
        bus.BTN = m;
        repeat (hold) @(negedge CLK);
        bus.BTN = '0;
        repeat (6) @(negedge CLK);
        model(m, sw);
    endtask

    task automatic read_at(input int a);
        press(5'b00100, 16'(a << 12), 2);
        press(5'b00010, 16'(a << 12), 2);
    endtask

    task automatic test_reset();
        bus.SW  = '0;
        bus.BTN = '0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_ptr  = 0;
        m_data = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.LED !== 16'h0000) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: LED=%h expected 0000", i, bus.LED);
            end
        end
    endtask

    task automatic test_write_sweep();
        for (int i = 0; i < 3; i++) begin
            press(5'b00001, 16'h00A5, 3);
            checks++;
            if (bus.LED !== exp_led()) begin
                failures++;
                $display("FAIL write_sweep %0d: LED=%h expected %h", i, bus.LED, exp_led());
            end
        end
        checks++;
        if (bus.LED !== 16'h30A5) begin
            failures++;
            $display("FAIL write_sweep_final: LED=%h expected 30A5", bus.LED);
        end
    endtask

    task automatic test_read_latency();
        logic [15:0] exp;
        press(5'b00100, 16'h5000, 2);
        press(5'b00001, 16'h5077, 2);
        press(5'b00100, 16'h1000, 2);
        @(negedge CLK);
        bus.SW  = 16'h1000;
        bus.BTN = 5'b00010;
        for (int e = 1; e <= 6; e++) begin
            @(negedge CLK);
            if (e == 3) bus.BTN = '0;
            exp = e < 5 ? 16'h1077 : 16'h10A5;
            checks++;
            if (bus.LED !== exp) begin
                failures++;
                $display("FAIL read_latency edge %0d: LED=%h expected %h", e, bus.LED, exp);
            end
        end
        model(5'b00010, 16'h1000);
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_wrap();
        press(5'b00100, 16'hF000, 2);
        press(5'b00001, 16'hF03C, 2);
        checks++;
        if (bus.LED !== 16'h003C || exp_led() !== 16'h003C) begin
            failures++;
            $display("FAIL wrap_write: LED=%h expected 003C", bus.LED);
        end
        press(5'b00100, 16'hF000, 2);
        press(5'b01000, 16'hF000, 2);
        checks++;
        if (bus.LED !== exp_led()) begin
            failures++;
            $display("FAIL wrap_inc: LED=%h expected %h", bus.LED, exp_led());
        end
        read_at(15);
        checks++;
        if (bus.LED !== 16'hF03C) begin
            failures++;
            $display("FAIL wrap_readback: LED=%h expected F03C", bus.LED);
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        @(negedge CLK);
        bus.SW  = 16'h00FF;
        bus.BTN = 5'b10000;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (k == 2)  bus.BTN = '0;
            if (k == 8)  bus.BTN = 5'b00001;
            if (k == 12) bus.BTN = '0;
            busy_cnt += int'(bus.LED[8]);
        end
        model(5'b10000, 16'h00FF);
        checks++;
        if (busy_cnt != 16) begin
            failures++;
            $display("FAIL clear_busy_cycles: got %0d expected 16", busy_cnt);
        end
        checks++;
        if (bus.LED !== 16'h0000) begin
            failures++;
            $display("FAIL clear_led: LED=%h expected 0000", bus.LED);
        end
        for (int a = 0; a < 16; a++) begin
            read_at(a);
            checks++;
            if (bus.LED !== exp_led() || bus.LED[7:0] !== 8'h00) begin
                failures++;
                $display("FAIL clear_readback addr %0d: LED=%h expected %h", a, bus.LED, exp_led());
            end
        end
    endtask

    task automatic test_priority();
        press(5'b00100, 16'h3000, 2);
        press(5'b01001, 16'h305A, 2);
        checks++;
        if (bus.LED !== 16'h405A || exp_led() !== 16'h405A) begin
            failures++;
            $display("FAIL prio_write_inc: LED=%h expected 405A", bus.LED);
        end
        press(5'b00101, 16'h9033, 2);
        checks++;
        if (bus.LED !== exp_led()) begin
            failures++;
            $display("FAIL prio_load_write: LED=%h expected %h", bus.LED, exp_led());
        end
        press(5'b01010, 16'h9033, 2);
        checks++;
        if (bus.LED !== exp_led()) begin
            failures++;
            $display("FAIL prio_read_inc: LED=%h expected %h", bus.LED, exp_led());
        end
        press(5'b01000, 16'h0000, 20);
        checks++;
        if (bus.LED !== exp_led()) begin
            failures++;
            $display("FAIL held_inc: LED=%h expected %h", bus.LED, exp_led());
        end
    endtask

    task automatic test_random();
        logic [4:0]  m;
        logic [15:0] sw;
        for (int i = 0; i < 40; i++) begin
            m  = 5'($urandom_range(1, 15));
            sw = 16'($urandom);
            press(m, sw, int'($urandom_range(1, 5)));
            checks++;
            if (bus.LED !== exp_led()) begin
                failures++;
                $display("FAIL random %0d btn=%b sw=%h: LED=%h expected %h", i, m, sw, bus.LED, exp_led());
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int k = 0;
        bit seen = 0;
        press(5'b00100, 16'h0000, 2);
        for (int i = 0; i < 16; i++) press(5'b00001, 16'(16'h0010 + i), 2);
        @(negedge CLK);
        bus.BTN = 5'b10000;
        while (!seen && k < 20) begin
            @(negedge CLK);
            if (k == 2) bus.BTN = '0;
            seen = bus.LED[8];
            k++;
        end
        bus.BTN = '0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL abort_busy_seen: busy=0 expected 1 within 20 cycles");
        end else begin
            repeat (5) @(posedge CLK);
            #1 RST = 1'b1;
            #1;
            checks++;
            if (bus.LED !== 16'h0000) begin
                failures++;
                $display("FAIL abort_led: LED=%h expected 0000", bus.LED);
            end
            @(negedge CLK);
            RST = 1'b0;
            m_ptr  = 0;
            m_data = 0;
            for (int i = 0; i < 5; i++) m_mem[i] = 0;
            for (int a = 0; a < 16; a++) begin
                read_at(a);
                checks++;
                if (bus.LED !== exp_led()) begin
                    failures++;
                    $display("FAIL abort_readback addr %0d: LED=%h expected %h", a, bus.LED, exp_led());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_sweep();
        test_read_latency();
        test_wrap();
        test_clear();
        test_priority();
        test_random();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/basys_mem_bank.md
Name: basys_mem_bank

Overview:
- Parametrised switch/button-driven memory bank for the Basys board; successor to the fixed 16-bit board memory block.
- SW supplies address and data fields; BTN issues commands (write, read, pointer load, increment, clear); LED shows the current pointer and read data.
- Adds over the previous generation: configurable data/address widths, auto-increment on write, a multi-cycle clear sweep with busy lockout, and a fixed command priority.

Parameters:
- DATA_W, 8, data word width; legal 1..12.
- ADDR_W, 4, address width, depth = 2**ADDR_W; constraint DATA_W+ADDR_W <= 16.
- DEBOUNCE_CYCLES, 16, stable-sample count used only when BASYS_MEM_DEBOUNCE_EN is defined.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- SW  input  16  SW[DATA_W-1:0] = write data; SW[15:16-ADDR_W] = address field.
- BTN  input  5  0=WRITE, 1=READ, 2=ADDR_LOAD, 3=INC, 4=CLEAR; asynchronous, level.
- LED  output  16  LED[DATA_W-1:0] = data register; LED[15:16-ADDR_W] = pointer; LED[DATA_W] = busy (clear in progress); unused bits are 0.

Behaviour:
- Reset (asynchronous, active-high):
  - pointer=0, data register=0, busy=0, FSM=IDLE, all sync/edge flops=0; LED=16'h0000.
  - Memory array is not reset.
- Button conditioning, per button:
  - 2-flop synchroniser, then rising-edge detect.
  - Produces a one-cycle command pulse on the 3rd rising CLK edge after BTN rises.
  - Held buttons produce exactly one pulse.
- Priority when several pulses coincide: CLEAR > ADDR_LOAD > WRITE > READ > INC. Lower-priority pulses in the same cycle are dropped.
- FSM states: IDLE, READ_WAIT, CLEAR.
- IDLE:
  - WRITE: mem[pointer] <= SW data; data register <= SW data (write-through); pointer <= pointer+1, wrapping 2**ADDR_W-1 -> 0. Stays IDLE.
  - READ: issue synchronous RAM read at pointer; go to READ_WAIT.
  - ADDR_LOAD: pointer <= SW address field.
  - INC: pointer <= pointer+1, with wrap.
  - CLEAR: busy <= 1; sweep counter <= 0; go to CLEAR.
- READ_WAIT: data register <= RAM output; return to IDLE. LED data updates 2 edges after the READ pulse. Pulses arriving in READ_WAIT are dropped.
- CLEAR:
  - Writes 0 to mem[sweep counter], one entry per cycle, for 2**ADDR_W cycles.
  - On the last entry: pointer <= 0, data register <= 0, busy <= 0, go to IDLE.
  - All pulses during CLEAR, including a repeated CLEAR, are dropped.
- Reset mid-CLEAR aborts the sweep. Entries already cleared remain 0; remaining entries are unchanged.
- Arithmetic: pointer and sweep counter are ADDR_W bits and wrap modulo 2**ADDR_W. No saturation.

Optional Feature:
- Macro: BASYS_MEM_DEBOUNCE_EN.
- Defined: after the synchroniser, a button level must be stable for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes. Pulse latency = 3 + DEBOUNCE_CYCLES edges. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: no debounce counter; pulse latency is 3 edges, and every synchronised rising edge produces a pulse.

Decomposition:
- Shared package basys_mem_pkg:
  - BTN index constants (BTN_WRITE=0, BTN_READ=1, BTN_ADDR_LOAD=2, BTN_INC=3, BTN_CLEAR=4).
  - FSM state enum (IDLE, READ_WAIT, CLEAR).
  - LED busy-bit position function of DATA_W.
- Sub-module btn_conditioner: synchroniser, optional debounce and edge detect, instantiated 5×. Ports CLK, RST, btn_in, pulse_out.

Test Plan (default parameters, macro undefined):
- Reset then idle: LED == 16'h0000 for 10 cycles after RST deasserts.
- Write sweep: SW=16'h00A5, press WRITE 3× -> mem[0..2]=A5. LED data=A5, pointer=3 (LED=16'h3 << 12 | 16'h00A5).
- Readback: SW address=1, press ADDR_LOAD, then READ -> LED[7:0]=8'hA5 exactly 2 edges after the READ pulse, pointer=1.
- Wrap: ADDR_LOAD 15, WRITE 8'h3C -> mem[15]=3C, pointer=0. INC at pointer 15 also wraps to 0.
- Clear and lockout: press CLEAR, then WRITE during the sweep.
  - LED[8]=1 for exactly 16 cycles.
  - WRITE is ignored.
  - Afterwards READ at every address returns 0; LED=16'h0000.
- Priority and reset:
  - WRITE+INC pressed the same cycle -> pointer advances by exactly 1.
  - RST asserted at sweep cycle 5 -> LED=0 immediately; mem[0..4]=0, mem[5..15] retain prior values.
